// File: rtl/div_pkg.sv
// Shared FP32 types and constants for the divider and its result collector.
// Pure definitions; no timing or flow control.
package div_pkg;

  localparam int FP_DW           = 32;
  localparam int DIV_LATENCY_DEF = 6;

  typedef logic [FP_DW-1:0] fp32_t;

  localparam fp32_t FP_ONE  = 32'h3F80_0000;
  localparam fp32_t FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/div_result_fifo.sv
// DW x DEPTH synchronous FIFO; head visible on pop_dat one cycle after the push.
// Push into a full FIFO is dropped unless a pop happens in the same cycle.
module div_result_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic [DW-1:0] pop_dat,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign pop_dat = mem[rd_ptr_q];

  // Pointers are exactly log2(DEPTH) bits, so increment wraps modulo DEPTH.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push & ~do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop & ~do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_dat;
    end
  end

endmodule

// File: rtl/div_result_collector.sv
// Credit-gated issue into the fixed-latency divider, FIFO-buffered results out; issue->out_valid is DIV_LATENCY+1.
// in_ready depends only on registered inflight+count; optional DIV_LAT_CHECK_EN flags off-schedule returns.
module div_result_collector
  import div_pkg::*;
#(
  parameter int SIG_WIDTH   = 23,
  parameter int EXP_WIDTH   = 8,
  parameter int DIV_LATENCY = DIV_LATENCY_DEF,
  parameter int DEPTH       = 8,
  parameter int DW          = SIG_WIDTH + EXP_WIDTH + 1,
  parameter int CW          = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] div_a,
  output logic [DW-1:0] div_b,
  output logic          div_ab_valid,
  input  logic [DW-1:0] div_z,
  input  logic          div_z_valid,
  output logic [DW-1:0] out_z,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] inflight,
  output logic          err
);

  logic [CW-1:0] inflight_q, inflight_d;
  logic          err_q, err_d;
  logic [CW:0]   credit_used;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic          issue, pop, ret_legal, ret_orphan, ret_overflow, lat_bad;

  assign credit_used  = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign in_ready     = (credit_used < (CW+1)'(DEPTH));
  assign issue        = in_valid & in_ready;
  assign div_a        = in_a;
  assign div_b        = in_b;
  assign div_ab_valid = issue;
  assign out_valid    = ~fifo_empty;
  assign pop          = out_valid & out_ready;
  assign inflight     = inflight_q;
  assign err          = err_q;

  assign ret_orphan   = div_z_valid & (inflight_q == '0);
  assign ret_legal    = div_z_valid & ~ret_orphan;
  assign ret_overflow = ret_legal & fifo_full & ~pop;

`ifdef DIV_LAT_CHECK_EN
  logic [DIV_LATENCY-1:0] lat_sr_q, lat_sr_d;

  // Tap DIV_LATENCY-1 goes high exactly in the cycle the divider should return.
  always_comb begin
    lat_sr_d = {lat_sr_q[DIV_LATENCY-2:0], issue};
    lat_bad  = (div_z_valid != lat_sr_q[DIV_LATENCY-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_sr_q <= '0;
    end else begin
      lat_sr_q <= lat_sr_d;
    end
  end
`else
  assign lat_bad = 1'b0;
`endif

  always_comb begin
    inflight_d = inflight_q;
    if (issue & ~ret_legal) begin
      inflight_d = inflight_q + CW'(1);
    end else if (ret_legal & ~issue) begin
      inflight_d = inflight_q - CW'(1);
    end
    err_d = err_q | ret_orphan | ret_overflow | lat_bad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  div_result_fifo #(
    .DW   (DW),
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (ret_legal),
    .push_dat(div_z),
    .pop     (pop),
    .pop_dat (out_z),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule
